// File: rtl/alu_operand_stage_if.sv
// Issue-side and ALU-side bus of the ALU operand-select stage.
// With FWD_WB_EN defined the bus also carries the write-back forwarding source.
interface alu_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [REG_AW-1:0] rs1_idx;
  logic [REG_AW-1:0] rs2_idx;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              ex_wr_en;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_data;
  logic              mem_wr_en;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
`ifdef FWD_WB_EN
  logic              wb_wr_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
`endif
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [1:0]        fwd_hit;

  modport master (
`ifdef FWD_WB_EN
    output wb_wr_en, wb_rd, wb_data,
`endif
    output in_valid, pc, rs1_data, rs2_data, imm, rs1_idx, rs2_idx, sel_a, sel_b,
    output ex_wr_en, ex_rd, ex_data, mem_wr_en, mem_rd, mem_data, flush, out_ready,
    input  in_ready, out_valid, op_a, op_b, fwd_hit
  );

  modport slave (
`ifdef FWD_WB_EN
    input  wb_wr_en, wb_rd, wb_data,
`endif
    input  in_valid, pc, rs1_data, rs2_data, imm, rs1_idx, rs2_idx, sel_a, sel_b,
    input  ex_wr_en, ex_rd, ex_data, mem_wr_en, mem_rd, mem_data, flush, out_ready,
    output in_ready, out_valid, op_a, op_b, fwd_hit
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered operand-select stage: builds op A / op B with EX/MEM forwarding and a 2-entry skid buffer.
// Optional macro FWD_WB_EN adds a write-back forwarding source (EX > MEM > WB > register file).
module alu_operand_fwd #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              ex_wr_en_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              mem_wr_en_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
`ifdef FWD_WB_EN
  input  logic              wb_wr_en_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
`endif
  output logic [XLEN-1:0]   data_o,
  output logic              hit_o
);
  // x0 is hardwired, so a pending write to it must never shadow the register file
  always_comb begin
    data_o = rf_data_i;
    hit_o  = 1'b0;
    if (idx_i != '0) begin
      if (ex_wr_en_i && (ex_rd_i == idx_i)) begin
        data_o = ex_data_i;
        hit_o  = 1'b1;
      end else if (mem_wr_en_i && (mem_rd_i == idx_i)) begin
        data_o = mem_data_i;
        hit_o  = 1'b1;
      end
`ifdef FWD_WB_EN
      else if (wb_wr_en_i && (wb_rd_i == idx_i)) begin
        data_o = wb_data_i;
        hit_o  = 1'b1;
      end
`endif
    end
  end
endmodule

module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int PC_INC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [1:0]      hit;
  } ent_t;

  logic [1:0][REG_AW-1:0] src_idx;
  logic [1:0][XLEN-1:0]   src_data;
  logic [1:0][XLEN-1:0]   fwd_data;
  logic [1:0]             fwd_m;

  assign src_idx  = {bus.rs2_idx, bus.rs1_idx};
  assign src_data = {bus.rs2_data, bus.rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    alu_operand_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
      .idx_i       (src_idx[g]),
      .rf_data_i   (src_data[g]),
      .ex_wr_en_i  (bus.ex_wr_en),
      .ex_rd_i     (bus.ex_rd),
      .ex_data_i   (bus.ex_data),
      .mem_wr_en_i (bus.mem_wr_en),
      .mem_rd_i    (bus.mem_rd),
      .mem_data_i  (bus.mem_data),
`ifdef FWD_WB_EN
      .wb_wr_en_i  (bus.wb_wr_en),
      .wb_rd_i     (bus.wb_rd),
      .wb_data_i   (bus.wb_data),
`endif
      .data_o      (fwd_data[g]),
      .hit_o       (fwd_m[g])
    );
  end

  ent_t ent_new;
  always_comb begin
    ent_new = '0;
    unique case (bus.sel_a)
      2'd1:    ent_new.a = fwd_data[0];
      2'd2:    ent_new.a = '0;
      default: ent_new.a = bus.pc;
    endcase
    unique case (bus.sel_b)
      2'd0:    ent_new.b = fwd_data[1];
      2'd2:    ent_new.b = XLEN'(PC_INC);
      default: ent_new.b = bus.imm;
    endcase
    ent_new.hit[0] = (bus.sel_a == 2'd1) && fwd_m[0];
    ent_new.hit[1] = (bus.sel_b == 2'd0) && fwd_m[1];
  end

  ent_t       ent_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  assign push = bus.in_valid && in_ready_q && !bus.flush;
  assign pop  = (cnt_q != 2'd0) && bus.out_ready && !bus.flush;

  // in_ready only looks at next occupancy: with <=1 entry any accept still fits, which is the skid
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.flush) begin
      cnt_d    = 2'd0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) ent_q[wr_ptr_q] <= ent_new;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  ent_t head;
  assign head          = ent_q[rd_ptr_q];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.op_a      = head.a;
  assign bus.op_b      = head.b;
  assign bus.fwd_hit   = (cnt_q != 2'd0) ? head.hit : 2'b00;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand select, forwarding, backpressure, flush, reset.
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  alu_operand_stage #(.XLEN(32), .REG_AW(5), .PC_INC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sa, input logic [1:0] sb, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.sel_a    = sa;
    bus.sel_b    = sb;
    bus.pc       = pc;
  endtask

  initial begin
    bus.in_valid = 0; bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0;
    bus.rs1_idx = 0; bus.rs2_idx = 0; bus.sel_a = 0; bus.sel_b = 0;
    bus.ex_wr_en = 0; bus.ex_rd = 0; bus.ex_data = 0;
    bus.mem_wr_en = 0; bus.mem_rd = 0; bus.mem_data = 0;
`ifdef FWD_WB_EN
    bus.wb_wr_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
`endif
    bus.flush = 0; bus.out_ready = 1;

    // reset state
    repeat (2) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_op_a",      bus.op_a,           32'd0);
    chk("rst_op_b",      bus.op_b,           32'd0);
    chk("rst_fwd_hit",   32'(bus.fwd_hit),   32'd0);
    rst_n = 1'b1;
    tick();

    // PC + PC_INC, no hazard
    issue(2'd0, 2'd2, 32'h100);
    tick();
    chk("pc_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pc_op_a",      bus.op_a,           32'h100);
    chk("pc_op_b",      bus.op_b,           32'd4);
    chk("pc_fwd_hit",   32'(bus.fwd_hit),   32'd0);

    // EX beats MEM on rs1
    issue(2'd1, 2'd1, 32'h0);
    bus.rs1_idx = 5; bus.rs1_data = 32'h11; bus.imm = 32'h7;
    bus.ex_wr_en = 1; bus.ex_rd = 5; bus.ex_data = 32'hAA;
    bus.mem_wr_en = 1; bus.mem_rd = 5; bus.mem_data = 32'hBB;
    tick();
    chk("exfwd_op_a", bus.op_a,         32'hAA);
    chk("exfwd_op_b", bus.op_b,         32'h7);
    chk("exfwd_hit",  32'(bus.fwd_hit), 32'd1);

    // MEM only, both operands from rs5
    bus.ex_wr_en = 0; bus.sel_b = 2'd0; bus.rs2_idx = 5; bus.rs2_data = 32'h22;
    tick();
    chk("memfwd_op_a", bus.op_a,         32'hBB);
    chk("memfwd_op_b", bus.op_b,         32'hBB);
    chk("memfwd_hit",  32'(bus.fwd_hit), 32'd3);

    // x0 never forwards; zero op A
    issue(2'd2, 2'd0, 32'h0);
    bus.rs2_idx = 0; bus.rs2_data = 0; bus.ex_wr_en = 1; bus.ex_rd = 0; bus.mem_wr_en = 0;
    tick();
    chk("x0_op_a", bus.op_a,         32'd0);
    chk("x0_op_b", bus.op_b,         32'd0);
    chk("x0_hit",  32'(bus.fwd_hit), 32'd0);

    // sel 3 aliases: no forwarding even with a matching EX write
    issue(2'd3, 2'd3, 32'h200);
    bus.ex_rd = 5; bus.imm = 32'h55;
    tick();
    chk("alias_op_a", bus.op_a,         32'h200);
    chk("alias_op_b", bus.op_b,         32'h55);
    chk("alias_hit",  32'(bus.fwd_hit), 32'd0);

    // rs1 index mismatch passes register data
    issue(2'd1, 2'd2, 32'h0);
    bus.rs1_idx = 6; bus.rs1_data = 32'h66;
    tick();
    chk("nomatch_op_a", bus.op_a,         32'h66);
    chk("nomatch_hit",  32'(bus.fwd_hit), 32'd0);
    bus.in_valid = 0; bus.ex_wr_en = 0;
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // backpressure: A held, B buffered, C blocked
    bus.out_ready = 0;
    issue(2'd0, 2'd2, 32'hA0);
    tick();
    chk("bp_a_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_a_op_a",  bus.op_a,           32'hA0);
    chk("bp_a_ready", 32'(bus.in_ready),  32'd1);
    issue(2'd0, 2'd2, 32'hB0);
    tick();
    chk("bp_b_op_a",  bus.op_a,          32'hA0);
    chk("bp_b_ready", 32'(bus.in_ready), 32'd0);
    issue(2'd0, 2'd2, 32'hC0);
    tick();
    chk("bp_c_hold",  bus.op_a,          32'hA0);
    chk("bp_c_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1;
    tick();
    chk("bp_out_b", bus.op_a, 32'hB0);
    tick();
    chk("bp_out_c",       bus.op_a,           32'hC0);
    chk("bp_out_c_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 0;
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // flush with two entries held and an input pending
    bus.out_ready = 0;
    issue(2'd0, 2'd2, 32'hD0);
    tick();
    issue(2'd0, 2'd2, 32'hE0);
    tick();
    issue(2'd0, 2'd2, 32'hF0);
    bus.flush = 1;
    tick();
    chk("fl2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl2_in_ready",  32'(bus.in_ready),  32'd1);
    bus.flush = 0; bus.in_valid = 0;
    tick();
    chk("fl2_no_stale", 32'(bus.out_valid), 32'd0);

    // flush with one entry and an acceptable input: input discarded too
    issue(2'd0, 2'd2, 32'h110);
    tick();
    issue(2'd0, 2'd2, 32'h120);
    bus.flush = 1;
    tick();
    bus.flush = 0; bus.in_valid = 0;
    chk("fl1_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("fl1_no_stale", 32'(bus.out_valid), 32'd0);
    issue(2'd0, 2'd2, 32'h130);
    tick();
    bus.in_valid = 0;
    chk("post_flush_op_a", bus.op_a, 32'h130);

    // asynchronous reset mid-operation
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_op_a",      bus.op_a,           32'd0);
    chk("arst_op_b",      bus.op_b,           32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
